// File: rtl/busca_instrucao_if.sv
// Instruction hand-off between the fetch stage and the ULA/control stage.
// The fetch stage presents opcode/endereco with valido; the consumer answers with pronto.
interface busca_instrucao_if;
    logic [3:0] opcode;
    logic [3:0] endereco;
    logic       valido;
    logic       pronto;

    modport master (
        output opcode,
        output endereco,
        output valido,
        input  pronto
    );

    modport slave (
        input  opcode,
        input  endereco,
        input  valido,
        output pronto
    );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: switch-loaded program memory, sequenced one word
// at a time onto a valid/ready bus until HALT or the last loaded word.
module busca_instrucao #(
    parameter int         PROF    = 16,
    parameter logic [3:0] OP_HALT = 4'hF
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       carregar,
    input  logic [7:0]                 dado_in,
    input  logic                       executar,
    busca_instrucao_if.master          bus,
    output logic [$clog2(PROF)-1:0]    pc,
    output logic [1:0]                 estado,
    output logic                       parado
);
    localparam int AW = $clog2(PROF);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX  = (AW + 1)'(PROF);

    typedef enum logic [1:0] {
        CARGA  = 2'b00,
        BUSCA  = 2'b01,
        EMITE  = 2'b10,
        PARADO = 2'b11
    } estado_t;

    estado_t       estado_r, estado_s;
    logic [AW-1:0] pc_r, pc_s;
    logic [AW-1:0] ptr_r, ptr_s;
    logic [AW:0]   cnt_r, cnt_s;
    logic [7:0]    ir_r, ir_s;
    logic          valido_r, valido_s;
    logic          parado_r, parado_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [7:0]    mem_r [PROF];

    // Next-state, pointer/counter and instruction-register logic
    always_comb begin
        estado_s   = estado_r;
        pc_s       = pc_r;
        ptr_s      = ptr_r;
        cnt_s      = cnt_r;
        ir_s       = ir_r;
        mem_we_s   = 1'b0;
        mem_addr_s = ptr_r;
        case (estado_r)
            CARGA: begin
                // A load in the same cycle as executar takes priority
                if (carregar) begin
                    mem_we_s = 1'b1;
                    ptr_s    = ptr_r + PTR_ONE;
                    if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else if (executar && (cnt_r != CNT_ZERO)) begin
                    estado_s = BUSCA;
                    pc_s     = PTR_ZERO;
                end else begin
                    estado_s = CARGA;
                end
            end
            BUSCA: begin
                ir_s     = mem_r[pc_r];
                estado_s = EMITE;
            end
            EMITE: begin
                if (bus.pronto) begin
                    if ((ir_r[7:4] == OP_HALT) || ({1'b0, pc_r} == (cnt_r - CNT_ONE))) begin
                        estado_s = PARADO;
                    end else begin
                        pc_s     = pc_r + PTR_ONE;
                        estado_s = BUSCA;
                    end
                end else begin
                    estado_s = EMITE;
                end
            end
            PARADO: begin
                // Loading from PARADO starts a fresh program at word 0
                if (carregar) begin
                    mem_we_s   = 1'b1;
                    mem_addr_s = PTR_ZERO;
                    ptr_s      = PTR_ONE;
                    cnt_s      = CNT_ONE;
                    estado_s   = CARGA;
                end else if (executar) begin
                    estado_s = BUSCA;
                    pc_s     = PTR_ZERO;
                end else begin
                    estado_s = PARADO;
                end
            end
            default: begin
                estado_s = CARGA;
            end
        endcase
        valido_s = (estado_s == EMITE);
        parado_s = (estado_s == PARADO);
    end

    // Control state and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_r <= CARGA;
            pc_r     <= PTR_ZERO;
            ptr_r    <= PTR_ZERO;
            cnt_r    <= CNT_ZERO;
            ir_r     <= 8'h00;
            valido_r <= 1'b0;
            parado_r <= 1'b0;
        end else begin
            estado_r <= estado_s;
            pc_r     <= pc_s;
            ptr_r    <= ptr_s;
            cnt_r    <= cnt_s;
            ir_r     <= ir_s;
            valido_r <= valido_s;
            parado_r <= parado_s;
        end
    end

    // Program memory; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= dado_in;
        end
    end

    assign bus.opcode   = ir_r[7:4];
    assign bus.endereco = ir_r[3:0];
    assign bus.valido   = valido_r;
    assign pc           = pc_r;
    assign estado       = estado_r;
    assign parado       = parado_r;
endmodule

// File: tb/tb_busca_instrucao.sv
// Scoreboard bench for busca_instrucao: a small program-memory model predicts
// every transfer, which is checked when the DUT presents it.
module tb_busca_instrucao;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       carregar = 1'b0;
    logic [7:0] dado_in = 8'h00;
    logic       executar = 1'b0;
    logic [3:0] pc;
    logic [1:0] estado;
    logic       parado;

    busca_instrucao_if bus_if ();

    busca_instrucao dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .carregar (carregar),
        .dado_in  (dado_in),
        .executar (executar),
        .bus      (bus_if.master),
        .pc       (pc),
        .estado   (estado),
        .parado   (parado)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  m_mem [16];
    int          m_ptr = 0;
    int          m_cnt = 0;
    bit          m_parado = 1'b0;
    logic [11:0] q [$];

    // Inputs are changed on the falling edge; entry and exit points of each task are falling edges.
    task automatic load(input logic [7:0] w);
        if (m_parado) begin
            m_mem[0] = w;
            m_ptr    = 1;
            m_cnt    = 1;
            m_parado = 1'b0;
        end else begin
            m_mem[m_ptr] = w;
            m_ptr = (m_ptr + 1) % 16;
            if (m_cnt < 16) m_cnt = m_cnt + 1;
        end
        carregar = 1'b1;
        dado_in  = w;
        @(negedge clock);
        carregar = 1'b0;
    endtask

    task automatic run_prog(input int stall);
        logic [3:0]  last_pc;
        logic [7:0]  last_w;
        logic [11:0] e;
        bit          prev_xfer;
        bit          done;
        int          st;
        st = stall;
        last_pc = 4'h0;
        last_w = 8'h00;
        q.delete();
        for (int i = 0; i < m_cnt; i++) begin
            q.push_back({4'(i), m_mem[i]});
            last_pc = 4'(i);
            last_w  = m_mem[i];
            if (m_mem[i][7:4] == 4'hF) break;
        end
        executar = 1'b1;
        bus_if.pronto = 1'b1;
        @(negedge clock);
        executar = 1'b0;
        vectors++;
        if (estado !== 2'b01 || bus_if.valido !== 1'b0) begin
            miscompares++;
            $display("FAIL start_busca: estado=%b valido=%b, want estado=01 valido=0", estado, bus_if.valido);
        end
        prev_xfer = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (parado === 1'b1) begin
                done = 1'b1;
                break;
            end
            if (bus_if.valido === 1'b1) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_transfer: pc=%h op=%h end=%h, want no valid word", pc, bus_if.opcode, bus_if.endereco);
                    bus_if.pronto = 1'b1;
                end else begin
                    e = q[0];
                    if ({pc, bus_if.opcode, bus_if.endereco} !== e || prev_xfer) begin
                        miscompares++;
                        $display("FAIL transfer: pc/op/end=%h back2back=%0d, want %h", {pc, bus_if.opcode, bus_if.endereco}, prev_xfer, e);
                    end
                    if (st > 0) begin
                        bus_if.pronto = 1'b0;
                        st--;
                    end else begin
                        bus_if.pronto = 1'b1;
                        void'(q.pop_front());
                    end
                end
            end else begin
                bus_if.pronto = 1'b1;
            end
            prev_xfer = (bus_if.valido === 1'b1) && bus_if.pronto;
            @(negedge clock);
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL timeout: parado=%b after 200 cycles, want 1", parado);
        end
        vectors++;
        if (q.size() != 0 || estado !== 2'b11 || bus_if.valido !== 1'b0 || pc !== last_pc ||
            {bus_if.opcode, bus_if.endereco} !== last_w) begin
            miscompares++;
            $display("FAIL end_state: left=%0d estado=%b valido=%b pc=%h word=%h, want left=0 estado=11 valido=0 pc=%h word=%h",
                     q.size(), estado, bus_if.valido, pc, {bus_if.opcode, bus_if.endereco}, last_pc, last_w);
        end
        m_parado = 1'b1;
        q.delete();
    endtask

    task automatic test_reset;
        bus_if.pronto = 1'b1;
        #1;
        vectors++;
        if (bus_if.valido !== 1'b0 || parado !== 1'b0 || pc !== 4'h0 || estado !== 2'b00 ||
            bus_if.opcode !== 4'h0 || bus_if.endereco !== 4'h0) begin
            miscompares++;
            $display("FAIL reset: valido=%b parado=%b pc=%h estado=%b op=%h end=%h, want all 0",
                     bus_if.valido, parado, pc, estado, bus_if.opcode, bus_if.endereco);
        end
        @(negedge clock);
        reset_n = 1'b1;
        m_ptr = 0;
        m_cnt = 0;
        m_parado = 1'b0;
        @(negedge clock);
        executar = 1'b1;
        @(negedge clock);
        executar = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (estado !== 2'b00 || bus_if.valido !== 1'b0) begin
                miscompares++;
                $display("FAIL exec_empty: estado=%b valido=%b, want 00/0", estado, bus_if.valido);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_basic;
        load(8'h12);
        load(8'h34);
        load(8'h56);
        run_prog(0);
    endtask

    task automatic test_backpressure;
        load(8'h12);
        load(8'h34);
        load(8'h56);
        run_prog(5);
    endtask

    task automatic test_halt;
        load(8'h21);
        load(8'hF0);
        load(8'h33);
        run_prog(0);
    endtask

    task automatic test_wrap;
        for (int i = 0; i <= 16; i++) load(8'(i));
        vectors++;
        if (m_mem[0] !== 8'h10 || m_cnt != 16) begin
            miscompares++;
            $display("FAIL wrap_model: mem0=%h cnt=%0d, want 10/16", m_mem[0], m_cnt);
        end
        run_prog(0);
    endtask

    task automatic test_restart_reload;
        run_prog(0);
        load(8'h77);
        vectors++;
        if (estado !== 2'b00 || parado !== 1'b0) begin
            miscompares++;
            $display("FAIL reload: estado=%b parado=%b, want 00/0", estado, parado);
        end
        run_prog(0);
    endtask

    task automatic test_reset_midrun;
        load(8'h12);
        load(8'h34);
        load(8'h56);
        bus_if.pronto = 1'b0;
        executar = 1'b1;
        @(negedge clock);
        executar = 1'b0;
        @(negedge clock);
        vectors++;
        if (bus_if.valido !== 1'b1 || {bus_if.opcode, bus_if.endereco} !== 8'h12) begin
            miscompares++;
            $display("FAIL pre_reset: valido=%b word=%h, want 1/12", bus_if.valido, {bus_if.opcode, bus_if.endereco});
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (bus_if.valido !== 1'b0 || parado !== 1'b0 || pc !== 4'h0 || estado !== 2'b00) begin
            miscompares++;
            $display("FAIL async_reset: valido=%b parado=%b pc=%h estado=%b, want 0/0/0/00", bus_if.valido, parado, pc, estado);
        end
        @(negedge clock);
        reset_n = 1'b1;
        bus_if.pronto = 1'b1;
        m_ptr = 0;
        m_cnt = 0;
        m_parado = 1'b0;
        @(negedge clock);
        executar = 1'b1;
        load(8'h45);
        executar = 1'b0;
        vectors++;
        if (estado !== 2'b00) begin
            miscompares++;
            $display("FAIL load_and_exec: estado=%b, want 00", estado);
        end
        run_prog(0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_halt;
        test_wrap;
        test_restart_reload;
        test_reset_midrun;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
